// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the SPI configuration sequencer: FSM states,
// width helpers and the default DA/ADRF register words for the board table ROM.
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Width of a counter that must hold 0..states-1; never narrower than one bit.
    function automatic int cnt_w(input int states);
        return (clog2(states) < 1) ? 1 : clog2(states);
    endfunction

    localparam logic [23:0] DA_TABLE [8] = '{
        24'h000081, 24'h010C00, 24'h020300, 24'h031000,
        24'h040000, 24'h050000, 24'h060400, 24'h070001
    };

    localparam logic [23:0] ADRF_TABLE [8] = '{
        24'h800010, 24'h810000, 24'h820021, 24'h830008,
        24'h840000, 24'h850300, 24'h860000, 24'h870001
    };

endpackage

// File: rtl/spi_cfg_seq_if.sv
// Board-side bundle of the configuration sequencer: table ROM port, SPI pins and status.
interface spi_cfg_seq_if #(
    parameter int NUM_DEV       = 2,
    parameter int WORD_W        = 24,
    parameter int WORDS_PER_DEV = 8
);
    localparam int ADDR_W = spi_cfg_pkg::cnt_w(NUM_DEV * WORDS_PER_DEV);

    logic [ADDR_W-1:0]  tbl_addr;
    logic [WORD_W-1:0]  tbl_data;
    logic               SPI_SCLK;
    logic               SPI_MOSI;
    logic [NUM_DEV-1:0] SPI_CS;
    logic [NUM_DEV-1:0] WRIEND;
    logic               BUSY;

    modport master (
        output tbl_addr, SPI_SCLK, SPI_MOSI, SPI_CS, WRIEND, BUSY,
        input  tbl_data
    );

    modport slave (
        input  tbl_addr, SPI_SCLK, SPI_MOSI, SPI_CS, WRIEND, BUSY,
        output tbl_data
    );

endinterface

// File: rtl/spi_cfg_shifter.sv
// Mode-0 word serialiser: loads one word, emits it MSB first with SCLK low for the
// first CLK_DIV cycles of each bit and high for the second, then pulses done.
module spi_cfg_shifter
    import spi_cfg_pkg::*;
#(
    parameter int WORD_W  = 24,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              abort,
    output logic              sclk,
    output logic              mosi,
    output logic              done
);
    localparam int HC_W = cnt_w(2 * CLK_DIV);
    localparam int BC_W = cnt_w(WORD_W);

    logic [WORD_W-1:0] shreg;
    logic [HC_W-1:0]   half_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic              active;
    logic              bit_end;

    assign bit_end = active && (half_cnt == HC_W'(2 * CLK_DIV - 1));
    assign done    = bit_end && (bit_cnt == BC_W'(WORD_W - 1));

    // MOSI moves on the same edge SCLK falls, so it is settled a full half-period before each rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else if (abort) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else if (load) begin
            shreg    <= load_data;
            mosi     <= load_data[WORD_W-1];
            half_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b1;
            sclk     <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                half_cnt <= '0;
                sclk     <= 1'b0;
                if (done) begin
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    mosi    <= shreg[WORD_W-2];
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                half_cnt <= half_cnt + 1'b1;
                if (half_cnt == HC_W'(CLK_DIV - 1)) sclk <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cfg_seq.sv
// SPI configuration sequencer: after clock lock and enable, walks the register table
// device by device and streams each word to its chip select; aborts on lock loss.
module spi_cfg_seq
    import spi_cfg_pkg::*;
#(
    parameter int NUM_DEV       = 2,
    parameter int WORD_W        = 24,
    parameter int WORDS_PER_DEV = 8,
    parameter int CLK_DIV       = 4,
    parameter int CS_GAP        = 4
) (
    input  logic          GCLK,
    input  logic          reset,
    input  logic          CMT_LOCKED,
    input  logic          SPI_EN,
    spi_cfg_seq_if.master bus
);
    localparam int ADDR_W = cnt_w(NUM_DEV * WORDS_PER_DEV);
    localparam int DEV_W  = cnt_w(NUM_DEV);
    localparam int WRD_W  = cnt_w(WORDS_PER_DEV);
    localparam int TMR_W  = cnt_w((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);

    state_t             state, state_next;
    logic [DEV_W-1:0]   dev, dev_next;
    logic [WRD_W-1:0]   word, word_next;
    logic [ADDR_W-1:0]  addr, addr_next;
    logic [TMR_W-1:0]   tmr, tmr_next;
    logic               armed, armed_next;
    logic [NUM_DEV-1:0] wriend, wriend_next;
    logic [NUM_DEV-1:0] cs_n, cs_n_next;
    logic               busy, busy_next;
    logic               start, abort, load, shift_done;
    logic               sclk, mosi;

    assign start = (state == S_IDLE) && armed && CMT_LOCKED && SPI_EN;
    assign abort = (state != S_IDLE) && !CMT_LOCKED;
    assign load  = (state == S_LOAD);

    spi_cfg_shifter #(
        .WORD_W (WORD_W),
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk      (GCLK),
        .rst_n    (reset),
        .load     (load),
        .load_data(bus.tbl_data),
        .abort    (abort),
        .sclk     (sclk),
        .mosi     (mosi),
        .done     (shift_done)
    );

    // The table address is a flat word index, so it simply counts alongside word/dev.
    always_comb begin
        state_next  = state;
        dev_next    = dev;
        word_next   = word;
        addr_next   = addr;
        tmr_next    = tmr;
        wriend_next = wriend;
        armed_next  = armed | ~SPI_EN;

        if (abort) begin
            state_next = S_IDLE;
            armed_next = 1'b1;
            tmr_next   = '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    state_next  = S_FETCH;
                    dev_next    = '0;
                    word_next   = '0;
                    addr_next   = '0;
                    tmr_next    = '0;
                    wriend_next = '0;
                    armed_next  = 1'b0;
                end
                S_FETCH: state_next = S_LOAD;
                S_LOAD:  state_next = S_SHIFT;
                S_SHIFT: if (shift_done) begin
                    state_next = S_HOLD;
                    tmr_next   = '0;
                end
                S_HOLD: begin
                    if (tmr == TMR_W'(CLK_DIV - 1)) begin
                        state_next = S_GAP;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr == TMR_W'(CS_GAP - 1)) begin
                        tmr_next   = '0;
                        state_next = S_FETCH;
                        addr_next  = addr + 1'b1;
                        if (word == WRD_W'(WORDS_PER_DEV - 1)) begin
                            wriend_next[dev] = 1'b1;
                            word_next        = '0;
                            if (dev == DEV_W'(NUM_DEV - 1)) begin
                                state_next = S_DONE;
                                addr_next  = addr;
                            end else begin
                                dev_next = dev + 1'b1;
                            end
                        end else begin
                            word_next = word + 1'b1;
                        end
                    end else begin
                        tmr_next = tmr + 1'b1;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end

        busy_next = (state_next == S_FETCH) || (state_next == S_LOAD) || (state_next == S_SHIFT) ||
                    (state_next == S_HOLD)  || (state_next == S_GAP);
        cs_n_next = '1;
        if ((state_next == S_SHIFT) || (state_next == S_HOLD)) cs_n_next[dev_next] = 1'b0;
    end

    // CS and BUSY are registered from the next-state decode so the pins never glitch.
    always_ff @(posedge GCLK or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            dev    <= '0;
            word   <= '0;
            addr   <= '0;
            tmr    <= '0;
            armed  <= 1'b1;
            wriend <= '0;
            cs_n   <= '1;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            dev    <= dev_next;
            word   <= word_next;
            addr   <= addr_next;
            tmr    <= tmr_next;
            armed  <= armed_next;
            wriend <= wriend_next;
            cs_n   <= cs_n_next;
            busy   <= busy_next;
        end
    end

    assign bus.tbl_addr = addr;
    assign bus.SPI_SCLK = sclk;
    assign bus.SPI_MOSI = mosi;
    assign bus.SPI_CS   = cs_n;
    assign bus.WRIEND   = wriend;
    assign bus.BUSY     = busy;

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Scoreboard bench for spi_cfg_seq: expected SPI words are queued by the stimulus and
// checked by per-instance monitors that decode each chip-select window.
module tb_spi_cfg_seq;
    import spi_cfg_pkg::*;

    typedef struct {
        logic [7:0]  cs;
        logic [31:0] data;
    } exp_t;

    logic GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    logic rst_n = 1'b1;
    logic lock_a = 1'b1, en_a = 1'b0;
    logic lock_b = 1'b0, en_b = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [23:0] table_a [16];
    logic [15:0] table_b [4];
    exp_t        qa[$];
    exp_t        qb[$];

    spi_cfg_seq_if #(.NUM_DEV(2), .WORD_W(24), .WORDS_PER_DEV(8)) bus_a ();
    spi_cfg_seq_if #(.NUM_DEV(3), .WORD_W(16), .WORDS_PER_DEV(1)) bus_b ();

    spi_cfg_seq #(.NUM_DEV(2), .WORD_W(24), .WORDS_PER_DEV(8), .CLK_DIV(4), .CS_GAP(4)) dut_a (
        .GCLK(GCLK), .reset(rst_n), .CMT_LOCKED(lock_a), .SPI_EN(en_a), .bus(bus_a)
    );

    spi_cfg_seq #(.NUM_DEV(3), .WORD_W(16), .WORDS_PER_DEV(1), .CLK_DIV(2), .CS_GAP(1)) dut_b (
        .GCLK(GCLK), .reset(rst_n), .CMT_LOCKED(lock_b), .SPI_EN(en_b), .bus(bus_b)
    );

    always @(posedge GCLK) cyc <= cyc + 1;
    always @(posedge GCLK) bus_a.tbl_data <= table_a[bus_a.tbl_addr];
    always @(posedge GCLK) bus_b.tbl_data <= table_b[bus_b.tbl_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic en);
        @(negedge GCLK);
        lock_a = lock;
        en_a   = en;
    endtask

    task automatic push_a(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.cs   = (i < 8) ? 8'h02 : 8'h01;
            e.data = 32'(table_a[i]);
            qa.push_back(e);
        end
    endtask

    task automatic wait_busy_a(input logic level, input int limit, input string name);
        int n = 0;
        while (bus_a.BUSY !== level && n < limit) begin @(negedge GCLK); n++; end
        if (n >= limit) checkOutput(name, 32'(bus_a.BUSY), 32'(level));
    endtask

    task automatic wait_busy_b(input logic level, input int limit, input string name);
        int n = 0;
        while (bus_b.BUSY !== level && n < limit) begin @(negedge GCLK); n++; end
        if (n >= limit) checkOutput(name, 32'(bus_b.BUSY), 32'(level));
    endtask

    task automatic wait_addr_a(input logic [3:0] value, input int limit, input string name);
        int n = 0;
        while (bus_a.tbl_addr !== value && n < limit) begin @(negedge GCLK); n++; end
        if (n >= limit) checkOutput(name, 32'(bus_a.tbl_addr), 32'(value));
    endtask

    task automatic wait_cs_a(input logic [1:0] value, input int limit, input string name);
        int n = 0;
        while (bus_a.SPI_CS !== value && n < limit) begin @(negedge GCLK); n++; end
        if (n >= limit) checkOutput(name, 32'(bus_a.SPI_CS), 32'(value));
    endtask

    // Monitor A: one decoded word per chip-select window, popped against the queue.
    logic [31:0] sh_a = '0;
    int          rises_a = 0;
    logic        in_win_a = 0, prev_sclk_a = 0, prev_mosi_a = 0, unstable_a = 0, multi_a = 0, ignore_a = 0;
    logic [7:0]  win_cs_a = '0;
    exp_t        e_a;

    always @(negedge GCLK) begin
        if (bus_a.SPI_CS != 2'b11) begin
            if (!in_win_a) begin
                in_win_a = 1; rises_a = 0; sh_a = '0; unstable_a = 0; multi_a = 0;
                win_cs_a = 8'(bus_a.SPI_CS);
            end
            if (8'(bus_a.SPI_CS) != win_cs_a || $countones(~bus_a.SPI_CS) != 1) multi_a = 1;
            if (bus_a.SPI_SCLK && !prev_sclk_a) begin
                rises_a++;
                sh_a = {sh_a[30:0], bus_a.SPI_MOSI};
                if (bus_a.SPI_MOSI != prev_mosi_a) unstable_a = 1;
            end
        end else if (in_win_a) begin
            in_win_a = 0;
            if (ignore_a && rises_a != 24) ignore_a = 0;
            else if (qa.size() == 0) checkOutput("a_unexpected_word", 32'(qa.size()), 32'd1);
            else begin
                e_a = qa.pop_front();
                checkOutput("a_cs", 32'(win_cs_a), e_a.cs);
                checkOutput("a_word", sh_a, e_a.data);
                checkOutput("a_rises", 32'(rises_a), 32'd24);
                checkOutput("a_mosi_stable", 32'(unstable_a), 32'd0);
                checkOutput("a_cs_onehot", 32'(multi_a), 32'd0);
            end
        end
        prev_sclk_a = bus_a.SPI_SCLK;
        prev_mosi_a = bus_a.SPI_MOSI;
    end

    logic [31:0] sh_b = '0;
    int          rises_b = 0;
    logic        in_win_b = 0, prev_sclk_b = 0, prev_mosi_b = 0, unstable_b = 0, multi_b = 0;
    logic [7:0]  win_cs_b = '0;
    exp_t        e_b;

    always @(negedge GCLK) begin
        if (bus_b.SPI_CS != 3'b111) begin
            if (!in_win_b) begin
                in_win_b = 1; rises_b = 0; sh_b = '0; unstable_b = 0; multi_b = 0;
                win_cs_b = 8'(bus_b.SPI_CS);
            end
            if (8'(bus_b.SPI_CS) != win_cs_b || $countones(~bus_b.SPI_CS) != 1) multi_b = 1;
            if (bus_b.SPI_SCLK && !prev_sclk_b) begin
                rises_b++;
                sh_b = {sh_b[30:0], bus_b.SPI_MOSI};
                if (bus_b.SPI_MOSI != prev_mosi_b) unstable_b = 1;
            end
        end else if (in_win_b) begin
            in_win_b = 0;
            if (qb.size() == 0) checkOutput("b_unexpected_word", 32'(qb.size()), 32'd1);
            else begin
                e_b = qb.pop_front();
                checkOutput("b_cs", 32'(win_cs_b), e_b.cs);
                checkOutput("b_word", sh_b, e_b.data);
                checkOutput("b_rises", 32'(rises_b), 32'd16);
                checkOutput("b_mosi_stable", 32'(unstable_b), 32'd0);
                checkOutput("b_cs_onehot", 32'(multi_b), 32'd0);
            end
        end
        prev_sclk_b = bus_b.SPI_SCLK;
        prev_mosi_b = bus_b.SPI_MOSI;
    end

    initial begin
        int   t_start, t7, t8;
        int   rises;
        logic seen, prev;
        exp_t e;

        for (int i = 0; i < 16; i++) table_a[i] = 24'hA50000 + 24'(i);
        table_b[0] = 16'hC3A0; table_b[1] = 16'hC3A1; table_b[2] = 16'hC3A2; table_b[3] = 16'h0000;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_cs", 32'(bus_a.SPI_CS), 32'h3);
        checkOutput("rst_sclk", 32'(bus_a.SPI_SCLK), 32'd0);
        checkOutput("rst_mosi", 32'(bus_a.SPI_MOSI), 32'd0);
        checkOutput("rst_wriend", 32'(bus_a.WRIEND), 32'd0);
        checkOutput("rst_busy", 32'(bus_a.BUSY), 32'd0);
        checkOutput("rst_addr", 32'(bus_a.tbl_addr), 32'd0);
        repeat (2) @(negedge GCLK);
        rst_n = 1'b1;
        repeat (2) @(negedge GCLK);

        // Full default run: 16 words of 202 cycles each.
        push_a(0, 15);
        applyStimulus(1'b1, 1'b1);
        wait_busy_a(1'b1, 10, "run1_busy_rise");
        t_start = cyc;
        checkOutput("run1_first_addr", 32'(bus_a.tbl_addr), 32'd0);
        wait_addr_a(4'd7, 2000, "run1_addr7");
        t7 = cyc;
        checkOutput("run1_wriend_mid_dev0", 32'(bus_a.WRIEND), 32'd0);
        wait_addr_a(4'd8, 400, "run1_addr8");
        t8 = cyc;
        checkOutput("run1_word_cycles", 32'(t8 - t7), 32'd202);
        checkOutput("run1_wriend_dev0", 32'(bus_a.WRIEND), 32'h1);
        wait_busy_a(1'b0, 4000, "run1_busy_fall");
        checkOutput("run1_total_cycles", 32'(cyc - t_start), 32'd3232);
        checkOutput("run1_wriend_all", 32'(bus_a.WRIEND), 32'h3);
        checkOutput("run1_queue_drained", 32'(qa.size()), 32'd0);

        seen = 1'b0;
        repeat (300) begin @(negedge GCLK); if (bus_a.BUSY) seen = 1'b1; end
        checkOutput("no_rerun_while_en_high", 32'(seen), 32'd0);

        // Re-arm by pulsing SPI_EN, then lose lock during device 1, word 3.
        push_a(0, 10);
        ignore_a = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        wait_busy_a(1'b1, 10, "run2_busy_rise");
        checkOutput("run2_wriend_cleared", 32'(bus_a.WRIEND), 32'd0);
        wait_addr_a(4'd11, 3000, "run2_addr11");
        wait_cs_a(2'b01, 10, "run2_cs_dev1");
        repeat (50) @(negedge GCLK);
        applyStimulus(1'b0, 1'b1);
        @(negedge GCLK);
        checkOutput("abort_cs", 32'(bus_a.SPI_CS), 32'h3);
        checkOutput("abort_sclk", 32'(bus_a.SPI_SCLK), 32'd0);
        checkOutput("abort_mosi", 32'(bus_a.SPI_MOSI), 32'd0);
        checkOutput("abort_busy", 32'(bus_a.BUSY), 32'd0);
        checkOutput("abort_wriend_kept", 32'(bus_a.WRIEND), 32'h1);
        @(negedge GCLK);
        checkOutput("abort_queue_drained", 32'(qa.size()), 32'd0);

        // Lock returns: full rerun from address 0, with one word of known bit pattern.
        table_a[3] = 24'h800001;
        push_a(0, 15);
        repeat (5) @(negedge GCLK);
        applyStimulus(1'b1, 1'b1);
        wait_busy_a(1'b1, 10, "run3_busy_rise");
        checkOutput("run3_first_addr", 32'(bus_a.tbl_addr), 32'd0);
        wait_busy_a(1'b0, 4000, "run3_busy_fall");
        checkOutput("run3_wriend_all", 32'(bus_a.WRIEND), 32'h3);
        @(negedge GCLK);
        checkOutput("run3_queue_drained", 32'(qa.size()), 32'd0);

        // Default DA/ADRF table, then an asynchronous reset in the middle of word 1.
        for (int i = 0; i < 8; i++) begin
            table_a[i]     = DA_TABLE[i];
            table_a[i + 8] = ADRF_TABLE[i];
        end
        e.cs = 8'h02; e.data = 32'(DA_TABLE[0]);
        qa.push_back(e);
        ignore_a = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        wait_addr_a(4'd1, 400, "run4_addr1");
        wait_cs_a(2'b10, 10, "run4_cs_dev0");
        repeat (30) @(negedge GCLK);
        applyStimulus(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cs", 32'(bus_a.SPI_CS), 32'h3);
        checkOutput("async_rst_sclk", 32'(bus_a.SPI_SCLK), 32'd0);
        checkOutput("async_rst_mosi", 32'(bus_a.SPI_MOSI), 32'd0);
        checkOutput("async_rst_busy", 32'(bus_a.BUSY), 32'd0);
        checkOutput("async_rst_addr", 32'(bus_a.tbl_addr), 32'd0);
        rises = 0;
        prev  = bus_a.SPI_SCLK;
        repeat (10) begin
            @(negedge GCLK);
            if (bus_a.SPI_SCLK && !prev) rises++;
            prev = bus_a.SPI_SCLK;
        end
        checkOutput("no_sclk_in_reset", 32'(rises), 32'd0);
        checkOutput("run4_queue_drained", 32'(qa.size()), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge GCLK);

        // Small configuration: three single-word devices, 69 cycles per word.
        e.cs = 8'h06; e.data = 32'(table_b[0]); qb.push_back(e);
        e.cs = 8'h05; e.data = 32'(table_b[1]); qb.push_back(e);
        e.cs = 8'h03; e.data = 32'(table_b[2]); qb.push_back(e);
        lock_b = 1'b1;
        en_b   = 1'b1;
        wait_busy_b(1'b1, 10, "b_busy_rise");
        t_start = cyc;
        wait_busy_b(1'b0, 400, "b_busy_fall");
        checkOutput("b_total_cycles", 32'(cyc - t_start), 32'd207);
        checkOutput("b_wriend_all", 32'(bus_b.WRIEND), 32'h7);
        @(negedge GCLK);
        checkOutput("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
